axis_row_padder: RTL and testbench



---
 rtl/axis_bram_pkg.sv | 17 +
 rtl/axis_skid_buffer.sv | 73 +++++++
 rtl/axis_row_padder.sv | 172 +++++++++++++++++
 tb/tb_axis_row_padder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_bram_pkg.sv
// rtl/axis_bram_pkg.sv - shared constants and types for the AXIS-to-BRAM row path
// Purpose : widths and the row-padder state type shared by axis_row_padder
//           and axis_bram_adapter.
// Ports   : none (package).
package axis_bram_pkg;

   localparam int AXIS_DATA_W    = 32;
   localparam int BRAM_ROW_BEATS = 36;
   localparam int BRAM_ADDR_W    = 12;
   localparam int BRAM_DATA_W    = AXIS_DATA_W * BRAM_ROW_BEATS;

   typedef enum logic {
      PASS = 1'b0,
      PAD  = 1'b1
   } row_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry registered skid buffer for a stream payload
// Purpose : decouples a stream so both ready and valid are registered while
//           still sustaining one beat per cycle.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           s_tvalid/s_tready - upstream handshake (s_tready registered)
//           s_tready_nxt      - value s_tready takes at the next edge
//           s_tdata           - upstream payload
//           m_tvalid/m_tready - downstream handshake (m_tvalid registered)
//           m_tdata           - downstream payload (registered)
module axis_skid_buffer
   import axis_bram_pkg::*;
#(
   parameter int WIDTH = AXIS_DATA_W + AXIS_DATA_W / 8 + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_tvalid,
   output logic             s_tready,
   output logic             s_tready_nxt,
   input  logic [WIDTH-1:0] s_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic [WIDTH-1:0] m_tdata
);

   logic [WIDTH-1:0] skid_data;
   logic             skid_valid;
   logic             skid_valid_nxt;
   logic             push;
   logic             load_out;

   // The skid entry only fills when a beat arrives while the output register
   // is occupied and stalled; it drains as soon as the output can reload.
   always_comb begin
      push     = s_tvalid && s_tready;
      load_out = !m_tvalid || m_tready;
      if (load_out) begin
         skid_valid_nxt = 1'b0;
      end else if (push) begin
         skid_valid_nxt = 1'b1;
      end else begin
         skid_valid_nxt = skid_valid;
      end
      s_tready_nxt = !skid_valid_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_tready   <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         m_tvalid   <= 1'b0;
         m_tdata    <= '0;
      end else begin
         s_tready   <= s_tready_nxt;
         skid_valid <= skid_valid_nxt;
         if (load_out) begin
            if (skid_valid) begin
               m_tvalid <= 1'b1;
               m_tdata  <= skid_data;
            end else begin
               m_tvalid <= push;
               if (push) begin
                  m_tdata <= s_tdata;
               end
            end
         end else if (push) begin
            skid_data <= s_tdata;
         end
      end
   end

endmodule

// File: rtl/axis_row_padder.sv
// rtl/axis_row_padder.sv - pads AXIS frames to a whole number of BRAM rows
// Purpose : forwards a frame beat for beat and appends pad beats so the
//           output tlast always lands on the last beat of a row.
// Ports   : axis_aclk, axis_areset      - clock, asynchronous active-high reset
//           s00_axis_*                  - input stream (tdata/tstrb/tlast)
//           m00_axis_*                  - output stream, pad beats have tstrb=0
//           frame_rows                  - rows in the last completed frame
//           frame_done                  - pulse after the output tlast handshake
module axis_row_padder
   import axis_bram_pkg::*;
#(
   parameter int                    DATA_WIDTH    = AXIS_DATA_W,
   parameter int                    BEATS_PER_ROW = BRAM_ROW_BEATS,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = '0,
   parameter int                    ROW_CNT_W     = BRAM_ADDR_W
) (
   input  logic                    axis_aclk,
   input  logic                    axis_areset,
   input  logic                    s00_axis_tvalid,
   output logic                    s00_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                    s00_axis_tlast,
   output logic                    m00_axis_tvalid,
   input  logic                    m00_axis_tready,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tlast,
   output logic [ROW_CNT_W-1:0]    frame_rows,
   output logic                    frame_done
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
   localparam int PAY_W  = DATA_WIDTH + STRB_W + 1;
   localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(BEATS_PER_ROW - 1);

   row_state_t           state;
   row_state_t           state_nxt;
   logic [CNT_W-1:0]     push_pos;
   logic [CNT_W-1:0]     beat_cnt;
   logic [ROW_CNT_W-1:0] row_cnt;
   logic [ROW_CNT_W-1:0] row_cnt_inc;
   logic                 s_ready_q;
   logic                 skid_in_valid;
   logic                 skid_in_ready;
   logic                 skid_ready_nxt;
   logic                 skid_push;
   logic [PAY_W-1:0]     skid_in_pay;
   logic [PAY_W-1:0]     skid_out_pay;
   logic                 out_hs;

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state <= PASS;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state. push_pos is the output row position the beat
   // entering the skid will occupy, so the decision is made on entry.
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         PASS: begin
            if (skid_push && s00_axis_tlast && (push_pos != LAST_POS)) begin
               state_nxt = PAD;
            end
         end
         PAD: begin
            if (skid_push && (push_pos == LAST_POS)) begin
               state_nxt = PASS;
            end
         end
         default: state_nxt = PASS;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs - mux input beats or pad beats into the skid
   // ---------------------------------------------------------------
   always_comb begin
      skid_in_valid = 1'b0;
      skid_in_pay   = '0;
      case (state)
         PASS: begin
            skid_in_valid = s00_axis_tvalid && s_ready_q;
            skid_in_pay   = {s00_axis_tdata, s00_axis_tstrb,
                             s00_axis_tlast && (push_pos == LAST_POS)};
         end
         PAD: begin
            skid_in_valid = 1'b1;
            skid_in_pay   = {PAD_VALUE, {STRB_W{1'b0}}, push_pos == LAST_POS};
         end
         default: begin
            skid_in_valid = 1'b0;
         end
      endcase
   end

   assign skid_push = skid_in_valid && skid_in_ready;

   // Input ready mirrors the skid's own registered ready, further closed
   // while padding so no beat of the next frame slips into the pad row.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         s_ready_q <= 1'b0;
         push_pos  <= '0;
      end else begin
         s_ready_q <= skid_ready_nxt && (state_nxt == PASS);
         if (skid_push) begin
            push_pos <= (push_pos == LAST_POS) ? '0 : push_pos + 1'b1;
         end
      end
   end

   assign s00_axis_tready = s_ready_q;

   axis_skid_buffer #(
      .WIDTH (PAY_W)
   ) u_skid (
      .clk          (axis_aclk),
      .rst          (axis_areset),
      .s_tvalid     (skid_in_valid),
      .s_tready     (skid_in_ready),
      .s_tready_nxt (skid_ready_nxt),
      .s_tdata      (skid_in_pay),
      .m_tvalid     (m00_axis_tvalid),
      .m_tready     (m00_axis_tready),
      .m_tdata      (skid_out_pay)
   );

   assign m00_axis_tdata = skid_out_pay[PAY_W-1 -: DATA_WIDTH];
   assign m00_axis_tstrb = skid_out_pay[STRB_W:1];
   assign m00_axis_tlast = skid_out_pay[0];

   // ---------------------------------------------------------------
   // Output-side beat/row accounting for frame_rows
   // ---------------------------------------------------------------
   assign out_hs      = m00_axis_tvalid && m00_axis_tready;
   assign row_cnt_inc = (row_cnt == '1) ? row_cnt : row_cnt + 1'b1;

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         beat_cnt   <= '0;
         row_cnt    <= '0;
         frame_rows <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= out_hs && m00_axis_tlast;
         if (out_hs) begin
            if (m00_axis_tlast) begin
               frame_rows <= row_cnt_inc;
               row_cnt    <= '0;
               beat_cnt   <= '0;
            end else if (beat_cnt == LAST_POS) begin
               beat_cnt <= '0;
               row_cnt  <= row_cnt_inc;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_row_padder.sv
// tb/tb_axis_row_padder.sv - directed self-checking bench for axis_row_padder
module tb_axis_row_padder;

   localparam int B = 36;

   logic        clk;
   logic        rst;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] s_tdata;
   logic [3:0]  s_tstrb;
   logic        s_tlast;
   logic        m_tvalid;
   logic        m_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic        m_tlast;
   logic [11:0] frame_rows;
   logic        frame_done;

   int errors;
   int checks;

   logic [31:0] in_data_q[$];
   logic [3:0]  in_strb_q[$];
   logic        in_last_q[$];
   logic [31:0] out_data_q[$];
   logic [3:0]  out_strb_q[$];
   logic        out_last_q[$];
   int          acc_cyc[$];
   int          done_cnt;
   int          pad_rdy_viol;
   int          stall_viol;
   int          stall_cnt;
   logic        stall_prev;
   logic [36:0] stall_pay;

   axis_row_padder dut (
      .axis_aclk       (clk),
      .axis_areset     (rst),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tready (s_tready),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tstrb  (s_tstrb),
      .s00_axis_tlast  (s_tlast),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tready (m_tready),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tstrb  (m_tstrb),
      .m00_axis_tlast  (m_tlast),
      .frame_rows      (frame_rows),
      .frame_done      (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor, sampled mid-cycle (inputs change just after posedge).
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (m_tvalid && m_tready) begin
            out_data_q.push_back(m_tdata);
            out_strb_q.push_back(m_tstrb);
            out_last_q.push_back(m_tlast);
            if (m_tstrb == 4'h0 && !m_tlast && s_tready) pad_rdy_viol++;
         end
         if (frame_done) done_cnt++;
         if (stall_prev && (!m_tvalid || {m_tdata, m_tstrb, m_tlast} != stall_pay)) stall_viol++;
         stall_prev = m_tvalid && !m_tready;
         stall_pay  = {m_tdata, m_tstrb, m_tlast};
         if (stall_prev) stall_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_queues();
      in_data_q.delete(); in_strb_q.delete(); in_last_q.delete();
      out_data_q.delete(); out_strb_q.delete(); out_last_q.delete();
      acc_cyc.delete();
      done_cnt = 0;
   endtask

   task automatic add_frame(input int n, input logic [31:0] d0, input logic [31:0] d1,
                            input bit vary_strb);
      for (int i = 0; i < n; i++) begin
         in_data_q.push_back((i % 2 == 0) ? d0 : d1);
         in_strb_q.push_back(vary_strb ? (4'(i) | 4'h1) : 4'hF);
         in_last_q.push_back(i == n - 1);
      end
   endtask

   task automatic send_frame();
      int  i;
      int  budget;
      logic hs;
      i = 0;
      budget = 0;
      while (i < in_data_q.size() && budget < 4000) begin
         s_tvalid = 1'b1;
         s_tdata  = in_data_q[i];
         s_tstrb  = in_strb_q[i];
         s_tlast  = in_last_q[i];
         @(negedge clk);
         hs = s_tready;
         @(posedge clk);
         #1;
         if (hs) begin
            acc_cyc.push_back(budget);
            i++;
         end
         budget++;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      check("send_complete", i, in_data_q.size());
   endtask

   task automatic wait_out(input int n);
      int c;
      c = 0;
      while (out_data_q.size() < n && c < 3000) begin
         @(posedge clk);
         c++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Expected output: every input beat, then zero-strobe pads up to the row end.
   function automatic int content_errs();
      logic [31:0] ed[$];
      logic [3:0]  es[$];
      logic        el[$];
      int pos;
      int e;
      int n;
      pos = 0;
      e = 0;
      for (int i = 0; i < in_data_q.size(); i++) begin
         ed.push_back(in_data_q[i]);
         es.push_back(in_strb_q[i]);
         el.push_back(in_last_q[i] && (pos == B - 1));
         if (in_last_q[i] && pos != B - 1) begin
            for (int p = pos + 1; p < B; p++) begin
               ed.push_back(32'h0);
               es.push_back(4'h0);
               el.push_back(p == B - 1);
            end
            pos = 0;
         end else begin
            pos = (pos == B - 1) ? 0 : pos + 1;
         end
      end
      if (ed.size() != out_data_q.size()) e++;
      n = (ed.size() < out_data_q.size()) ? ed.size() : out_data_q.size();
      for (int i = 0; i < n; i++) begin
         if (ed[i] !== out_data_q[i] || es[i] !== out_strb_q[i] || el[i] !== out_last_q[i]) e++;
      end
      return e;
   endfunction

   task automatic bp_loop(input int n);
      for (int c = 0; c < 4000 && out_data_q.size() < n; c++) begin
         @(posedge clk);
         #1;
         m_tready = 1'($urandom_range(0, 1));
      end
      m_tready = 1'b1;
   endtask

   initial begin
      int c;
      errors = 0;
      checks = 0;
      done_cnt = 0;
      pad_rdy_viol = 0;
      stall_viol = 0;
      stall_cnt = 0;
      stall_prev = 1'b0;
      stall_pay = '0;
      rst = 1'b1;
      s_tvalid = 1'b0;
      s_tdata = '0;
      s_tstrb = '0;
      s_tlast = 1'b0;
      m_tready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tstrb", m_tstrb, 0);
      check("rst_tready", s_tready, 0);
      check("rst_frame_rows", frame_rows, 0);
      check("rst_frame_done", frame_done, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_release", s_tready, 1);

      // 1: exact row, no pad
      clear_queues();
      add_frame(36, 32'h0, 32'hFFFF_FFFF, 1'b0);
      send_frame();
      wait_out(36);
      check("t1_beats", out_data_q.size(), 36);
      check("t1_content", content_errs(), 0);
      check("t1_done_pulses", done_cnt, 1);
      check("t1_frame_rows", frame_rows, 1);

      // 2: single beat, 35 pads
      clear_queues();
      pad_rdy_viol = 0;
      add_frame(1, 32'hAAAA_AAAA, 32'h0, 1'b0);
      send_frame();
      wait_out(36);
      check("t2_beats", out_data_q.size(), 36);
      check("t2_content", content_errs(), 0);
      check("t2_ready_in_pad", pad_rdy_viol, 0);
      check("t2_done_pulses", done_cnt, 1);
      check("t2_frame_rows", frame_rows, 1);

      // 3: 40-beat frame -> 72 beats, 32 pads, 2 rows
      clear_queues();
      add_frame(40, 32'hAAAA_AAAA, 32'hCCCC_CCCC, 1'b1);
      send_frame();
      wait_out(72);
      check("t3_beats", out_data_q.size(), 72);
      check("t3_content", content_errs(), 0);
      check("t3_done_pulses", done_cnt, 1);
      check("t3_frame_rows", frame_rows, 2);

      // 4: test 3 under random backpressure
      clear_queues();
      stall_viol = 0;
      stall_cnt = 0;
      add_frame(40, 32'hAAAA_AAAA, 32'hCCCC_CCCC, 1'b1);
      fork
         send_frame();
         bp_loop(72);
      join
      wait_out(72);
      check("t4_beats", out_data_q.size(), 72);
      check("t4_content", content_errs(), 0);
      check("t4_stall_stable", stall_viol, 0);
      check("t4_stalls_seen", stall_cnt > 0, 1);
      check("t4_frame_rows", frame_rows, 2);

      // 5: reset five beats into the pad run of a single-beat frame
      clear_queues();
      add_frame(1, 32'hAAAA_AAAA, 32'h0, 1'b0);
      send_frame();
      c = 0;
      while (out_data_q.size() < 6 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("t5_reached_pad", out_data_q.size(), 6);
      #2;
      rst = 1'b1;
      #1;
      check("t5_tvalid_async", m_tvalid, 0);
      check("t5_ready_in_rst", s_tready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_queues();
      add_frame(36, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      send_frame();
      wait_out(36);
      check("t5_beats", out_data_q.size(), 36);
      check("t5_content", content_errs(), 0);
      check("t5_frame_rows", frame_rows, 1);
      check("t5_done_pulses", done_cnt, 1);

      // 6: back-to-back 36 / 1 / 36 with tvalid held high
      clear_queues();
      add_frame(36, 32'h1111_1111, 32'h2222_2222, 1'b0);
      add_frame(1, 32'h3333_3333, 32'h0, 1'b0);
      add_frame(36, 32'h4444_4444, 32'h5555_5555, 1'b1);
      send_frame();
      wait_out(108);
      check("t6_first_frame_cycles", (acc_cyc.size() >= 36) ? acc_cyc[35] : -1, 35);
      check("t6_beats", out_data_q.size(), 108);
      check("t6_content", content_errs(), 0);
      check("t6_done_pulses", done_cnt, 3);
      check("t6_frame_rows", frame_rows, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
